// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell stepped over WIDTH cycles per add.
// Operands are captured on start; the result registers update only when the add completes.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s_c,
   output logic co_c
);
   assign s_c  = a ^ b ^ ci;
   assign co_c = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int unsigned       CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ADD  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] s_sr;
   logic             carry;
   logic             c_msb_in;
   logic [CNT_W-1:0] cnt;
   logic             last_c;
   logic             c_msb_in_c;
   logic             fa_s;
   logic             fa_co;

   full_adder fa (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .ci   (carry),
      .s_c  (fa_s),
      .co_c (fa_co)
   );

   // Final bit is being computed; the pre-update carry is the carry into the MSB.
   always_comb begin
      last_c     = (state == S_ADD) && (cnt == CNT_LAST);
      c_msb_in_c = last_c ? carry : c_msb_in;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_ADD;
         S_ADD:   if (last_c) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt == S_ADD);
         done  <= (state_nxt == S_DONE);
      end
   end

   // Shift datapath; visible results load only on the completing edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_sr     <= '0;
         b_sr     <= '0;
         s_sr     <= '0;
         carry    <= 1'b0;
         c_msb_in <= 1'b0;
         cnt      <= '0;
         sum      <= '0;
         cout     <= 1'b0;
         ovf      <= 1'b0;
      end else begin
         c_msb_in <= c_msb_in_c;
         if (state == S_IDLE && start) begin
            a_sr  <= a_in;
            b_sr  <= b_in;
            carry <= cin_in;
            cnt   <= '0;
         end else if (state == S_ADD) begin
            a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
            s_sr  <= {fa_s, s_sr[WIDTH-1:1]};
            carry <= fa_co;
            cnt   <= last_c ? '0 : cnt + CNT_W'(1);
            if (last_c) begin
               sum  <= {fa_s, s_sr[WIDTH-1:1]};
               cout <= fa_co;
               ovf  <= c_msb_in_c ^ fa_co;
            end
         end
      end
   end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: 8-bit and 5-bit instances checked every cycle
// against an arithmetic model, plus directed cases with literal expectations.

module tb_serial_adder_ctrl;
   localparam int unsigned W8 = 8;
   localparam int unsigned W5 = 5;

   logic         clk;
   logic         rst8, start8, cin8, busy8, done8, cout8, ovf8;
   logic [7:0]   a8, b8, sum8;
   logic         rst5, start5, cin5, busy5, done5, cout5, ovf5;
   logic [4:0]   a5, b5, sum5;

   int           n_checks;
   int           n_fail;
   int unsigned  edge_n;
   bit           chk_en;
   bit           init_done;
   bit           sweep5_done;

   // Model state per instance: k = edges since acceptance (0 = idle)
   int           k      [2];
   logic [31:0]  pa     [2];
   logic [31:0]  pb     [2];
   logic         pc     [2];
   logic [31:0]  e_sum  [2];
   logic         e_cout [2];
   logic         e_ovf  [2];

   serial_adder_ctrl #(.WIDTH(W8)) dut8 (
      .clk(clk), .reset(rst8), .start(start8), .a_in(a8), .b_in(b8), .cin_in(cin8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
   );

   serial_adder_ctrl #(.WIDTH(W5)) dut5 (
      .clk(clk), .reset(rst5), .start(start5), .a_in(a5), .b_in(b5), .cin_in(cin5),
      .busy(busy5), .done(done5), .sum(sum5), .cout(cout5), .ovf(ovf5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      edge_n   = 0;
   end

   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int to_signed(input logic [31:0] v, input int w);
      return v[w-1] ? int'(v) - (1 << w) : int'(v);
   endfunction

   task automatic model_edge(input int d, input int w, input logic rst, input logic st,
                             input logic [31:0] a, input logic [31:0] b, input logic c);
      longint r;
      longint m;
      int     s;
      int     lim;
      if (rst) begin
         k[d] = 0; e_sum[d] = 0; e_cout[d] = 1'b0; e_ovf[d] = 1'b0;
      end else if (k[d] == 0) begin
         if (st) begin
            k[d] = 1; pa[d] = a; pb[d] = b; pc[d] = c;
         end
      end else begin
         k[d] = k[d] + 1;
         if (k[d] == w + 1) begin
            m         = longint'(1) << w;
            r         = longint'(pa[d]) + longint'(pb[d]) + longint'(pc[d]);
            e_sum[d]  = 32'(r % m);
            e_cout[d] = ((r / m) != 0);
            s         = to_signed(pa[d], w) + to_signed(pb[d], w) + int'(pc[d]);
            lim       = 1 << (w - 1);
            e_ovf[d]  = (s >= lim) || (s < -lim);
         end else if (k[d] == w + 2) begin
            k[d] = 0;
         end
      end
   endtask

   always @(posedge clk) begin
      model_edge(0, 8, rst8, start8, 32'(a8), 32'(b8), cin8);
      model_edge(1, 5, rst5, start5, 32'(a5), 32'(b5), cin5);
   end

   // Per-cycle comparison of both instances against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("w8_busy", 33'(busy8), 33'(k[0] >= 1 && k[0] <= 8));
         check("w8_done", 33'(done8), 33'(k[0] == 9));
         check("w8_sum",  33'(sum8),  33'(e_sum[0]));
         check("w8_cout", 33'(cout8), 33'(e_cout[0]));
         check("w8_ovf",  33'(ovf8),  33'(e_ovf[0]));
         check("w5_busy", 33'(busy5), 33'(k[1] >= 1 && k[1] <= 5));
         check("w5_done", 33'(done5), 33'(k[1] == 6));
         check("w5_sum",  33'(sum5),  33'(e_sum[1]));
         check("w5_cout", 33'(cout5), 33'(e_cout[1]));
         check("w5_ovf",  33'(ovf5),  33'(e_ovf[1]));
      end
   end

   task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                          output logic [7:0] s, output logic co, output logic ov,
                          output int lat, output int busy_n);
      int unsigned t0;
      @(negedge clk);
      start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
      @(negedge clk);
      start8 = 1'b0; a8 = ~a; b8 = ~b; cin8 = ~c;
      t0 = edge_n; lat = -1; busy_n = 0;
      for (int i = 0; i < 40; i++) begin
         if (busy8) busy_n++;
         if (done8) begin
            lat = int'(edge_n - t0);
            break;
         end
         @(negedge clk);
      end
      s = sum8; co = cout8; ov = ovf8;
   endtask

   task automatic op8_check(input string nm, input logic [7:0] a, input logic [7:0] b,
                            input logic c, input logic [7:0] es, input logic eco, input logic eov);
      logic [7:0] s;
      logic       co, ov;
      int         lat, bn;
      run_op8(a, b, c, s, co, ov, lat, bn);
      check({nm, "_sum"},  33'(s),  33'(es));
      check({nm, "_cout"}, 33'(co), 33'(eco));
      check({nm, "_ovf"},  33'(ov), 33'(eov));
      check({nm, "_lat"},  33'(lat), 33'(8));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // dut5: 1000 random adds, run alongside the 8-bit tests
   initial begin
      logic [4:0]  a, b;
      logic        c;
      logic [5:0]  r;
      int unsigned t0;
      int          lat;
      sweep5_done = 1'b0;
      wait (init_done);
      for (int n = 0; n < 1000; n++) begin
         a = 5'($urandom); b = 5'($urandom); c = 1'($urandom);
         r = 6'(a) + 6'(b) + 6'(c);
         @(negedge clk);
         start5 = 1'b1; a5 = a; b5 = b; cin5 = c;
         @(negedge clk);
         start5 = 1'b0; a5 = 5'($urandom); b5 = 5'($urandom);
         t0 = edge_n; lat = -1;
         for (int i = 0; i < 30; i++) begin
            if (done5) begin
               lat = int'(edge_n - t0);
               break;
            end
            @(negedge clk);
         end
         check("w5_sweep_sum",  33'(sum5),  33'(r[4:0]));
         check("w5_sweep_cout", 33'(cout5), 33'(r[5]));
         check("w5_sweep_lat",  33'(lat),   33'(5));
      end
      sweep5_done = 1'b1;
   end

   initial begin
      logic [7:0]  s, a, b;
      logic        co, ov, c;
      logic [8:0]  r;
      int          lat, bn, done_seen;
      int unsigned t0;

      chk_en = 1'b0; init_done = 1'b0;
      rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
      rst5 = 1'b1; start5 = 1'b0; a5 = '0; b5 = '0; cin5 = 1'b0;
      repeat (3) @(negedge clk);
      rst8 = 1'b0; rst5 = 1'b0;
      chk_en = 1'b1;
      init_done = 1'b1;

      check("rst_busy", 33'(busy8), 33'(0));
      check("rst_done", 33'(done8), 33'(0));
      check("rst_sum",  33'(sum8),  33'(0));
      check("rst_cout", 33'(cout8), 33'(0));
      check("rst_ovf",  33'(ovf8),  33'(0));

      run_op8(8'h35, 8'h4A, 1'b0, s, co, ov, lat, bn);
      check("basic_sum",    33'(s),   33'(8'h7F));
      check("basic_cout",   33'(co),  33'(0));
      check("basic_ovf",    33'(ov),  33'(0));
      check("basic_lat",    33'(lat), 33'(8));
      check("basic_busy_n", 33'(bn),  33'(8));

      op8_check("ff_01",   8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      op8_check("7f_01",   8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      op8_check("ff_ff_1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

      // Start ignored during ADD and DONE; inputs change after capture
      @(negedge clk);
      start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
      @(negedge clk);
      start8 = 1'b0;
      t0 = edge_n;
      @(negedge clk);
      @(negedge clk);
      check("hold_sum",  33'(sum8),  33'(8'hFF));
      check("hold_cout", 33'(cout8), 33'(1));
      start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
      @(negedge clk);
      start8 = 1'b0; a8 = 8'hC3; b8 = 8'h3C;
      for (int i = 0; i < 20 && !done8; i++) @(negedge clk);
      check("ign_lat", 33'(edge_n - t0), 33'(8));
      check("ign_sum", 33'(sum8), 33'(8'h30));
      start8 = 1'b1; a8 = 8'h03; b8 = 8'h04; cin8 = 1'b0;
      for (int i = 0; i < 20 && !busy8; i++) @(negedge clk);
      check("restart_edge", 33'(edge_n - t0), 33'(10));
      start8 = 1'b0;
      for (int i = 0; i < 20 && !done8; i++) @(negedge clk);
      check("restart_sum", 33'(sum8), 33'(8'h07));

      // Reset in the middle of ADD aborts the operation
      op8_check("pre_abort", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
      @(negedge clk);
      start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      rst8 = 1'b1;
      @(negedge clk);
      rst8 = 1'b0;
      check("abort_busy", 33'(busy8), 33'(0));
      check("abort_sum",  33'(sum8),  33'(0));
      check("abort_cout", 33'(cout8), 33'(0));
      check("abort_ovf",  33'(ovf8),  33'(0));
      done_seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (done8) done_seen++;
      end
      check("abort_no_done", 33'(done_seen), 33'(0));
      op8_check("post_abort", 8'h0F, 8'h01, 1'b1, 8'h11, 1'b0, 1'b0);

      for (int n = 0; n < 1000; n++) begin
         a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
         r = 9'(a) + 9'(b) + 9'(c);
         run_op8(a, b, c, s, co, ov, lat, bn);
         check("w8_sweep_sum",  33'(s),   33'(r[7:0]));
         check("w8_sweep_cout", 33'(co),  33'(r[8]));
         check("w8_sweep_lat",  33'(lat), 33'(8));
      end

      for (int i = 0; i < 20000 && !sweep5_done; i++) @(negedge clk);
      check("w5_sweep_finished", 33'(sweep5_done), 33'(1));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
